ssp_tx_engine: RTL

//   Transmit half of the SSP. Holds APB-written bytes in a 4-deep transmit FIFO.

---
 rtl/ssp_tx_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ssp_tx_engine.sv
// ssp_tx_engine
//   Transmit half of the SSP. APB writes are queued in a small FIFO and each
//   byte is serialized MSB-first on ssptxd, preceded by a one-bit-period
//   sspfssout pulse. Frames run back-to-back while the FIFO has data.
//
// Ports
//   pclk       in   system clock, rising edge
//   clr_b      in   synchronous reset, active-high
//   psel       in   APB select
//   pwrite     in   APB write strobe (push = psel & pwrite & !full)
//   pwdata     in   word to enqueue
//   sspclkout  out  free-running serial clock
//   sspfssout  out  frame sync, high for the bit period before each MSB
//   ssptxd     out  serial data, updated on sspclkout rising ticks only
//   ssptxintr  out  FIFO full
//   tx_empty   out  FIFO empty
//   tx_busy    out  serializer not idle
module ssp_tx_engine #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DIV_HALF = 1
) (
    input  logic              pclk,
    input  logic              clr_b,
    input  logic              psel,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              sspclkout,
    output logic              sspfssout,
    output logic              ssptxd,
    output logic              ssptxintr,
    output logic              tx_empty,
    output logic              tx_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StFsync, StShift} state_e;

    // ---------------- clock divider ----------------
    logic [CW-1:0] r_div_cnt;
    logic          r_sspclk;
    logic          w_div_wrap;
    logic          w_rise_tick;

    assign w_div_wrap  = (r_div_cnt == CW'(DIV_HALF - 1));
    // The serializer advances on the edge where sspclkout goes 0->1.
    assign w_rise_tick = w_div_wrap & ~r_sspclk;

    always_ff @(posedge pclk) begin
        if (clr_b) begin
            r_div_cnt <= '0;
            r_sspclk  <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_sspclk  <= ~r_sspclk;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // ---------------- FIFO ----------------
    logic [AW:0]       r_wptr, r_rptr;
    logic [AW:0]       w_wptr_nxt, w_rptr_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_full, r_empty;
    logic              w_push, w_pop;

    // Full is the registered pre-pop value, so a push on a full FIFO is
    // dropped even if the serializer pops on the same edge.
    assign w_push     = psel & pwrite & ~r_full;
    assign w_wptr_nxt = w_push ? r_wptr + (AW+1)'(1) : r_wptr;
    assign w_rptr_nxt = w_pop  ? r_rptr + (AW+1)'(1) : r_rptr;

    always_ff @(posedge pclk) begin
        if (clr_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]) &&
                       (w_wptr_nxt[AW] != w_rptr_nxt[AW]);
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= pwdata;
        end
    end

    // ---------------- serializer FSM ----------------
    state_e            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_sr, w_sr_nxt;
    logic [BW-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic              r_fss, w_fss_nxt;
    logic              r_txd, w_txd_nxt;

    // State and datapath registers
    always_ff @(posedge pclk) begin
        if (clr_b) begin
            r_state  <= StIdle;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_fss    <= 1'b0;
            r_txd    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sr     <= w_sr_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_fss    <= w_fss_nxt;
            r_txd    <= w_txd_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_rise_tick) begin
            unique case (r_state)
                StIdle:  if (!r_empty) w_state_nxt = StFsync;
                StFsync: w_state_nxt = StShift;
                StShift: begin
                    if (r_bitcnt == '0) begin
                        w_state_nxt = r_empty ? StIdle : StFsync;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Outputs, pop and shift datapath
    always_comb begin
        w_pop        = 1'b0;
        w_sr_nxt     = r_sr;
        w_bitcnt_nxt = r_bitcnt;
        w_fss_nxt    = r_fss;
        w_txd_nxt    = r_txd;
        if (w_rise_tick) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_empty) begin
                        w_pop     = 1'b1;
                        w_sr_nxt  = r_mem[r_rptr[AW-1:0]];
                        w_fss_nxt = 1'b1;
                        w_txd_nxt = 1'b0;
                    end
                end
                StFsync: begin
                    w_fss_nxt    = 1'b0;
                    w_txd_nxt    = r_sr[DATA_W-1];
                    w_bitcnt_nxt = BW'(DATA_W - 1);
                end
                StShift: begin
                    if (r_bitcnt != '0) begin
                        w_sr_nxt     = r_sr << 1;
                        w_txd_nxt    = r_sr[DATA_W-2];
                        w_bitcnt_nxt = r_bitcnt - BW'(1);
                    end else if (!r_empty) begin
                        // Next frame's sync overlaps the period right after the LSB.
                        w_pop     = 1'b1;
                        w_sr_nxt  = r_mem[r_rptr[AW-1:0]];
                        w_fss_nxt = 1'b1;
                        w_txd_nxt = 1'b0;
                    end else begin
                        w_txd_nxt = 1'b0;
                    end
                end
                default: begin
                    w_fss_nxt = 1'b0;
                    w_txd_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sspclkout = r_sspclk;
    assign sspfssout = r_fss;
    assign ssptxd    = r_txd;
    assign ssptxintr = r_full;
    assign tx_empty  = r_empty;
    assign tx_busy   = (r_state != StIdle);

endmodule
